// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller.
// A single 4-bit ripple-carry slice is reused once per cycle, LS nibble first,
// with the inter-nibble carry held in a register. Results (sum/cout/overflow)
// are published only when the last nibble completes and hold until the next
// completion or reset.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   overflow
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [W-1:0]     opa;
   logic [W-1:0]     opb;
   logic [W-1:0]     work_sum;
   logic [W-1:0]     work_next;
   logic             carry;
   logic [IDX_W-1:0] idx;

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_s;
   logic [4:0]       slice_c;

   // State register; reset dominates everything and aborts any operation.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
   // combinational blocks below use blocking (=) because they describe wires.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: IDLE -> RUN on start, RUN until the last nibble, DONE for one cycle.
   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (idx == LAST_IDX) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded straight from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         IDLE:    ;
         RUN:     busy = 1'b1;
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Shared 4-bit ripple-carry slice working on the nibble selected by idx.
   always_comb begin
      slice_a    = opa[idx*4 +: 4];
      slice_b    = opb[idx*4 +: 4];
      slice_s    = 4'h0;
      slice_c    = 5'h00;
      slice_c[0] = carry;
      for (int i = 0; i < 4; i++) begin
         slice_s[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
         slice_c[i+1] = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
      end
   end

   // Work-sum with the current slice result merged into nibble idx.
   always_comb begin
      work_next              = work_sum;
      work_next[idx*4 +: 4]  = slice_s;
   end

   // Datapath: operand capture on accept, nibble accumulation in RUN, publish on the last nibble.
   // NOTE: the operand/work registers are plain flops, not a RAM, so they are reset
   // along with everything else to guarantee no stale data survives an abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         opa      <= '0;
         opb      <= '0;
         work_sum <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  opa   <= a;
                  // Subtraction is a + ~b + 1, so invert B and force the carry-in.
                  opb   <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               work_sum <= work_next;
               carry    <= slice_c[4];
               idx      <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  // Publish on the edge entering DONE; slice_c[3] is the carry into bit W-1.
                  sum      <= work_next;
                  cout     <= slice_c[4];
                  overflow <= slice_c[3] ^ slice_c[4];
               end
            end
            DONE:    ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIBBLES=4), hand-computed expectations.
module tb_nibble_serial_adder_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk;
   logic          reset;
   logic          start;
   logic          sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;

   int            n_checks;
   int            n_errors;

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Pulse start for one edge with the given operands; returns at the negedge after accept.
   task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                         input logic tsub);
      @(negedge clk);
      a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Full operation: checks latency, busy length, result and post-done idle.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tcin, input logic tsub, input logic [W-1:0] esum,
                         input logic ecout, input logic eovf);
      int edges;
      int busy_cycles;
      accept(ta, tb_, tcin, tsub);
      edges       = 0;
      busy_cycles = busy ? 1 : 0;
      while (!done && edges < 20) begin
         @(negedge clk);
         edges++;
         if (busy) busy_cycles++;
      end
      check({tag, ".latency"}, 32'(edges), 32'(NIBBLES));
      check({tag, ".busy_len"}, 32'(busy_cycles), 32'(NIBBLES + 1));
      check({tag, ".sum"}, 32'(sum), 32'(esum));
      check({tag, ".cout"}, 32'(cout), 32'(ecout));
      check({tag, ".ovf"}, 32'(overflow), 32'(eovf));
      @(negedge clk);
      check({tag, ".done_clr"}, 32'(done), 32'd0);
      check({tag, ".busy_clr"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dones;
      int edges;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.sum",  32'(sum),  32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.ovf",  32'(overflow), 32'd0);
      reset = 1'b0;

      // IDLE with start low stays idle.
      repeat (3) @(negedge clk);
      check("idle.busy", 32'(busy), 32'd0);

      run_op("add1",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
      run_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("wrapc", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("ovfp",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("ovfn",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("borrow",16'h0005, 16'h0008, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

      // Starts during RUN and DONE must be ignored.
      accept(16'h0001, 16'h0001, 1'b0, 1'b0);
      a = 16'hAAAA; b = 16'h5555;
      dones = 0;
      @(negedge clk); start = 1'b1;              // RUN cycle 2
      @(negedge clk); start = 1'b0;
      edges = 0;
      while (!done && edges < 20) begin @(negedge clk); edges++; end
      check("ign.done_seen", 32'(done), 32'd1);
      check("ign.sum", 32'(sum), 32'h0002);
      start = 1'b1;                               // held across the DONE edge
      @(negedge clk); start = 1'b0;
      if (done) dones++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("ign.extra_done", 32'(dones), 32'd0);
      check("ign.sum_hold", 32'(sum), 32'h0002);
      run_op("after_ign", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

      // Reset in the 2nd RUN cycle aborts the operation.
      accept(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);     // now in RUN cycle 1
      @(negedge clk);                              // RUN cycle 2
      reset = 1'b1;
      @(negedge clk);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.sum",  32'(sum),  32'd0);
      check("abort.cout", 32'(cout), 32'd0);
      check("abort.ovf",  32'(overflow), 32'd0);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort.no_done", 32'(dones), 32'd0);
      run_op("fresh", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
